// File: rtl/dram_master_if.sv
// Signal bundle for dram_master: command channel, store/load streams and the data-RAM port.
interface dram_master_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 64
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [4:0]    cmd_len;
  logic          cmd_err;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          ram_ena;
  logic          ram_rea;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dia;
  logic [DW-1:0] ram_doa;

  // Controller side: takes commands, initiates RAM accesses.
  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_doa,
    output cmd_ready, cmd_err, wr_ready, rd_valid, rd_data, rd_last, busy,
    output ram_ena, ram_rea, ram_wea, ram_addra, ram_dia
  );

  // Host side: issues commands and streams, and stands in for the RAM.
  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_doa,
    input  cmd_ready, cmd_err, wr_ready, rd_valid, rd_data, rd_last, busy,
    input  ram_ena, ram_rea, ram_wea, ram_addra, ram_dia
  );
endinterface

// File: rtl/dram_master.sv
// Burst load/store controller for the 64-bit data RAM port; hides the RAM's one-cycle read
// latency behind a 2-entry credit-managed output FIFO.
module dram_master #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 64
) (
  input  logic         clk,
  input  logic         reset,
  dram_master_if.slave bus
);
  localparam int unsigned LW = 5;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] remain_q, remain_d;
  logic          err_q, err_d;
  logic          inflight_q, inflight_last_q;
  logic [DW-1:0] fifo_data_q [2];
  logic          fifo_last_q [2];
  logic          wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  logic [AW:0]   end_addr;
  logic          cmd_bad;
  logic          pop;
  logic          credit;
  logic          last_word;
  logic          issue;
  logic          wbeat;

  // Range check one bit wider than the address so addr+len cannot wrap.
  assign end_addr  = {1'b0, bus.cmd_addr} + (AW+1)'(bus.cmd_len);
  assign cmd_bad   = (bus.cmd_len == '0) || (end_addr > (AW+1)'(DEPTH));
  assign pop       = (cnt_q != '0) && bus.rd_ready;
  assign credit    = ({1'b0, cnt_q} + (CW+1)'(inflight_q)) < ((CW+1)'(2) + (CW+1)'(pop));
  assign last_word = (remain_q == LW'(1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    err_d    = 1'b0;
    issue    = 1'b0;
    wbeat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d   = bus.cmd_addr;
            remain_d = bus.cmd_len;
            state_d  = bus.cmd_we ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          wbeat    = 1'b1;
          addr_d   = addr_q + AW'(1);
          remain_d = remain_q - LW'(1);
          if (last_word) state_d = IDLE;
        end
      end
      READ: begin
        if ((remain_q != '0) && credit) begin
          issue    = 1'b1;
          addr_d   = addr_q + AW'(1);
          remain_d = remain_q - LW'(1);
          if (last_word) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (cnt_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      err_q           <= err_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_word;
    end
  end

  // Output FIFO: RAM data lands one cycle after its issue, tagged with the burst-last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wptr_q] <= bus.ram_doa;
        fifo_last_q[wptr_q] <= inflight_last_q;
        wptr_q              <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + CW'(inflight_q) - CW'(pop);
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.cmd_err   = err_q;
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_valid  = (cnt_q != '0);
  assign bus.rd_data   = fifo_data_q[rptr_q];
  assign bus.rd_last   = (cnt_q != '0) && fifo_last_q[rptr_q];

  // Strobes follow the beat/issue in the same cycle; address and data are zeroed when idle.
  assign bus.ram_ena   = wbeat || issue;
  assign bus.ram_wea   = wbeat;
  assign bus.ram_rea   = issue;
  assign bus.ram_addra = (wbeat || issue) ? addr_q : '0;
  assign bus.ram_dia   = wbeat ? bus.wr_data : '0;
endmodule
